// File: rtl/wb_stream_loader_if.sv
// Byte-stream, control/status and Wishbone master signals of wb_stream_loader.
// master: the loader itself; slave: the environment (stream source, controller, RAM).
interface wb_stream_loader_if #(
  parameter int ADR_WIDTH = 11
);
  logic [7:0]           rx_data_i;
  logic                 rx_valid_i;
  logic                 rx_ready_o;
  logic                 start_i;
  logic                 flush_i;
  logic                 busy_o;
  logic                 err_o;
  logic [ADR_WIDTH-2:0] words_o;
  logic                 wb_cyc_o;
  logic                 wb_stb_o;
  logic                 wb_we_o;
  logic [31:0]          wb_adr_o;
  logic [31:0]          wb_dat_o;
  logic [3:0]           wb_sel_o;
  logic [31:0]          wb_dat_i;
  logic                 wb_ack_i;

  modport master (
    input  rx_data_i, rx_valid_i, start_i, flush_i, wb_dat_i, wb_ack_i,
    output rx_ready_o, busy_o, err_o, words_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );

  modport slave (
    output rx_data_i, rx_valid_i, start_i, flush_i, wb_dat_i, wb_ack_i,
    input  rx_ready_o, busy_o, err_o, words_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );
endinterface

// File: rtl/wb_stream_loader.sv
// Packs a byte stream little-endian into 32-bit Wishbone writes at auto-incrementing word addresses.
// Optional read-back verify of every written word is built when WB_LOADER_READBACK_EN is defined.
module wb_stream_loader #(
  parameter logic [31:0] BASE_ADR       = 32'h0000_0000,
  parameter int          ADR_WIDTH      = 11,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  wb_stream_loader_if.master bus
);

  localparam int IDX_W = ADR_WIDTH - 2;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_COLLECT = 3'd0,
    S_WRITE   = 3'd1,
    S_GAP     = 3'd2,
    S_VERIFY  = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_k;
  logic [3:0]           r_sel;
  logic [31:0]          r_word;
  logic [IDX_W-1:0]     r_idx;
  logic [ADR_WIDTH-2:0] r_words;
  logic                 r_flush_pend;
  logic                 r_err;
  logic [TMO_W-1:0]     r_tmo;

  logic w_in_bus;
  logic w_accept;
  logic w_flush_req;
  logic w_tmo_hit;
  logic w_clear;
  logic w_advance;
  logic w_set_err;

  assign w_in_bus    = (r_state == S_WRITE) || (r_state == S_VERIFY);
  // start_i wins over a byte offered in the same cycle; that byte is dropped
  assign w_accept    = (r_state == S_COLLECT) && bus.rx_valid_i && !bus.start_i;
  assign w_flush_req = bus.flush_i || r_flush_pend;
  assign w_tmo_hit   = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

`ifdef WB_LOADER_READBACK_EN
  logic [31:0] w_sel_mask;
  logic        w_rb_ok;

  assign w_sel_mask = {{8{r_sel[3]}}, {8{r_sel[2]}}, {8{r_sel[1]}}, {8{r_sel[0]}}};
  assign w_rb_ok    = ((bus.wb_dat_i ^ r_word) & w_sel_mask) == 32'h0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_advance   = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      S_COLLECT: begin
        if (bus.start_i) begin
          w_clear = 1'b1;
        end else if (w_accept && (r_k == 2'd3)) begin
          w_state_nxt = S_WRITE;
        end else if (w_flush_req && ((r_k != 2'd0) || w_accept)) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.wb_ack_i) begin
`ifdef WB_LOADER_READBACK_EN
          w_state_nxt = S_GAP;
`else
          w_state_nxt = S_COLLECT;
          w_advance   = 1'b1;
`endif
        end else if (w_tmo_hit) begin
          w_state_nxt = S_ERROR;
          w_set_err   = 1'b1;
        end
      end
`ifdef WB_LOADER_READBACK_EN
      // idle cycle lets the RAM's toggling ack register fall before the read
      S_GAP: begin
        w_state_nxt = S_VERIFY;
      end
      S_VERIFY: begin
        if (bus.wb_ack_i) begin
          if (w_rb_ok) begin
            w_state_nxt = S_COLLECT;
            w_advance   = 1'b1;
          end else begin
            w_state_nxt = S_ERROR;
            w_set_err   = 1'b1;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = S_ERROR;
          w_set_err   = 1'b1;
        end
      end
`endif
      S_ERROR: begin
        if (bus.start_i) begin
          w_state_nxt = S_COLLECT;
          w_clear     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_k          <= 2'd0;
      r_sel        <= 4'h0;
      r_word       <= 32'h0;
      r_idx        <= '0;
      r_words      <= '0;
      r_flush_pend <= 1'b0;
      r_err        <= 1'b0;
    end else if (w_clear) begin
      r_k          <= 2'd0;
      r_sel        <= 4'h0;
      r_word       <= 32'h0;
      r_idx        <= '0;
      r_words      <= '0;
      r_flush_pend <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_word[{r_k, 3'b000} +: 8] <= bus.rx_data_i;
        r_sel[r_k]                 <= 1'b1;
        r_k                        <= r_k + 2'd1;
      end
      // clearing the word keeps unselected lanes of a later partial write at zero
      if (w_advance) begin
        r_idx  <= r_idx + 1'b1;
        r_k    <= 2'd0;
        r_sel  <= 4'h0;
        r_word <= 32'h0;
        if (r_words != '1) begin
          r_words <= r_words + 1'b1;
        end
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end
      if (r_state == S_COLLECT) begin
        r_flush_pend <= 1'b0;
      end else if (bus.flush_i) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tmo <= '0;
    end else if (w_in_bus) begin
      r_tmo <= r_tmo + 1'b1;
    end else begin
      r_tmo <= '0;
    end
  end

  assign bus.rx_ready_o = (r_state == S_COLLECT);
  assign bus.busy_o     = (r_state != S_COLLECT);
  assign bus.err_o      = r_err;
  assign bus.words_o    = r_words;
  assign bus.wb_cyc_o   = w_in_bus;
  assign bus.wb_stb_o   = w_in_bus;
  assign bus.wb_we_o    = (r_state == S_WRITE);
  assign bus.wb_adr_o   = w_in_bus ? (BASE_ADR + {{(32-ADR_WIDTH){1'b0}}, r_idx, 2'b00}) : 32'h0;
  assign bus.wb_dat_o   = (r_state == S_WRITE) ? r_word : 32'h0;
  assign bus.wb_sel_o   = w_in_bus ? r_sel : 4'h0;

endmodule

// File: tb/tb_wb_stream_loader.sv
// Bench for wb_stream_loader: toggling-ack RAM model, directed scenarios, then random bytes/flushes
// checked against a queue-based packing model.
module tb_wb_stream_loader;
  localparam int          ADR_W = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          TMO   = 16;
  localparam int          NW    = 1 << (ADR_W - 2);
  localparam int          WMAX  = (1 << (ADR_W - 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_stream_loader_if #(.ADR_WIDTH(ADR_W)) bus ();

  wb_stream_loader #(
    .BASE_ADR      (BASE),
    .ADR_WIDTH     (ADR_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // RAM slave model: ack one cycle after stb, then low for one cycle
  logic        ack_en  = 1'b1;
  logic [31:0] corrupt = 32'h0;
  logic [31:0] mem [16];
  logic        s_pend;
  logic [3:0]  s_widx;
  logic [31:0] obs_adr[$];
  logic [31:0] obs_dat[$];
  logic [3:0]  obs_sel[$];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      s_pend = ack_en && bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_ack_i;
      if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_we_o && bus.wb_ack_i) begin
        s_widx = bus.wb_adr_o[5:2];
        for (int b = 0; b < 4; b++)
          if (bus.wb_sel_o[b]) mem[s_widx][8*b +: 8] = bus.wb_dat_o[8*b +: 8];
        obs_adr.push_back(bus.wb_adr_o);
        obs_dat.push_back(bus.wb_dat_o);
        obs_sel.push_back(bus.wb_sel_o);
      end
      @(posedge clk);
      #1;
      bus.wb_ack_i = s_pend;
      bus.wb_dat_i = s_pend ? (mem[bus.wb_adr_o[5:2]] ^ corrupt) : 32'h0;
    end
  end

  // reference model: bytes fill lanes 0..3, a write happens on the 4th byte or a flush
  int          m_k, m_idx, m_cnt;
  logic [31:0] m_word;
  logic [3:0]  m_sel;
  logic [31:0] exp_adr[$];
  logic [31:0] exp_dat[$];
  logic [3:0]  exp_sel[$];

  task automatic model_reset();
    m_k = 0; m_idx = 0; m_cnt = 0; m_word = 32'h0; m_sel = 4'h0;
  endtask

  task automatic model_emit();
    exp_adr.push_back(BASE + 32'(m_idx * 4));
    exp_dat.push_back(m_word);
    exp_sel.push_back(m_sel);
    m_idx  = (m_idx + 1) % NW;
    m_cnt  = (m_cnt < WMAX) ? m_cnt + 1 : WMAX;
    m_k    = 0;
    m_word = 32'h0;
    m_sel  = 4'h0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic fl);
    m_word = m_word | (32'(b) << (8 * m_k));
    m_sel  = m_sel | 4'(1 << m_k);
    m_k++;
    if (m_k == 4 || fl) model_emit();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fl);
    int  n = 0;
    bit  done = 0;
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    bus.flush_i    = fl;
    while (!done && n < 200) begin
      @(negedge clk);
      if (bus.rx_ready_o) done = 1;
      @(posedge clk);
      #1;
      n++;
    end
    bus.rx_valid_i = 1'b0;
    bus.flush_i    = 1'b0;
    if (!done) check("byte_accept_timeout", 0, 1);
    else model_byte(b, fl);
  endtask

  task automatic do_flush();
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    if (m_k > 0) model_emit();
  endtask

  task automatic do_start();
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    model_reset();
  endtask

  task automatic wait_idle();
    int n = 0;
    bit idle = 0;
    while (!idle && n < 200) begin
      @(negedge clk);
      if (!bus.busy_o && !bus.wb_cyc_o) idle = 1;
      n++;
    end
    @(posedge clk);
    #1;
    if (!idle) check("idle_timeout", 0, 1);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, obs_adr.size(), exp_adr.size());
    while (obs_adr.size() > 0 && exp_adr.size() > 0) begin
      check({tag, "_adr"}, obs_adr.pop_front(), exp_adr.pop_front());
      check({tag, "_dat"}, obs_dat.pop_front(), exp_dat.pop_front());
      check({tag, "_sel"}, obs_sel.pop_front(), exp_sel.pop_front());
    end
    obs_adr.delete(); obs_dat.delete(); obs_sel.delete();
    exp_adr.delete(); exp_dat.delete(); exp_sel.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] b;
    bus.rx_data_i  = 8'h0;
    bus.rx_valid_i = 1'b0;
    bus.start_i    = 1'b0;
    bus.flush_i    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.rx_ready_o, 1);
    check("rst_busy_err", {bus.busy_o, bus.err_o}, 0);
    check("rst_words", bus.words_o, 0);
    check("rst_ctl", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o}, 0);
    check("rst_adr_dat", {bus.wb_adr_o, bus.wb_dat_o}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // two full words, with cycle timing around the 4th byte
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    check("t_n1_stb_we", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}, 3'b111);
    check("t_n1_adr", bus.wb_adr_o, BASE);
    check("t_n1_dat_sel", {bus.wb_dat_o, bus.wb_sel_o}, {32'h4433_2211, 4'hF});
    @(posedge clk); #1;
    check("t_n2_stb", bus.wb_stb_o, 1);
    @(posedge clk); #1;
`ifdef WB_LOADER_READBACK_EN
    check("t_n3_gap", {bus.busy_o, bus.wb_stb_o}, 2'b10);
    @(posedge clk); #1;
    check("t_n4_read", {bus.wb_stb_o, bus.wb_we_o}, 2'b10);
    @(posedge clk); #1;
    check("t_n5_read", bus.wb_stb_o, 1);
    @(posedge clk); #1;
    check("t_n6_ready", {bus.wb_stb_o, bus.rx_ready_o}, 2'b01);
`else
    check("t_n3_ready", {bus.wb_stb_o, bus.rx_ready_o}, 2'b01);
`endif
    send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
    wait_idle();
    compare_writes("two_words");
    check("two_words_cnt", bus.words_o, 2);

    // partial word via flush, next byte lands at word 1 lane 0
    do_start();
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    do_flush();
    wait_idle();
    check("partial_cnt", bus.words_o, 1);
    send_byte(8'hCC, 1);
    wait_idle();
    compare_writes("partial");

    // flush with the 4th byte, then a flush during WRITE with k=0
    do_start();
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 1);
    wait_idle();
    send_byte(8'h05, 0); send_byte(8'h06, 0); send_byte(8'h07, 0); send_byte(8'h08, 0);
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    compare_writes("flush_same");
    check("flush_same_cnt", bus.words_o, 2);

    // address wrap and count saturation
    do_start();
    for (int i = 0; i < 20; i++) send_byte(8'($urandom), 0);
    wait_idle();
    check("wrap_cnt", bus.words_o, 5);
    compare_writes("wrap");
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 0);
    wait_idle();
    check("sat_cnt", bus.words_o, WMAX);
    compare_writes("sat");

    // slave never acks
    do_start();
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'(i + 8'h40), 0);
    n = 0;
    while (bus.wb_stb_o && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check("tmo_stb_cycles", n, TMO);
    check("tmo_err_ready", {bus.err_o, bus.rx_ready_o, bus.wb_cyc_o}, 3'b100);
    bus.rx_valid_i = 1'b1;
    bus.flush_i    = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rx_ready_o) n++;
    end
    @(posedge clk); #1;
    bus.rx_valid_i = 1'b0;
    bus.flush_i    = 1'b0;
    check("tmo_locked", n, 0);
    check("tmo_err_held", bus.err_o, 1);
    obs_adr.delete(); obs_dat.delete(); obs_sel.delete();
    exp_adr.delete(); exp_dat.delete(); exp_sel.delete();
    ack_en = 1'b1;
    do_start();
    check("tmo_cleared", {bus.err_o, bus.rx_ready_o}, 2'b01);
    send_byte(8'h5A, 1);
    wait_idle();
    compare_writes("after_tmo");

    // asynchronous reset in the middle of a write
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'(i), 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_drop", {bus.wb_cyc_o, bus.wb_stb_o, bus.rx_ready_o}, 3'b001);
    @(posedge clk); #1;
    rst = 1'b0;
    ack_en = 1'b1;
    model_reset();
    obs_adr.delete(); obs_dat.delete(); obs_sel.delete();
    exp_adr.delete(); exp_dat.delete(); exp_sel.delete();
    @(posedge clk); #1;
    send_byte(8'hE1, 0); send_byte(8'hE2, 1);
    wait_idle();
    compare_writes("after_arst");

`ifdef WB_LOADER_READBACK_EN
    do_start();
    corrupt = 32'h00FF_0000;
    for (int i = 0; i < 4; i++) send_byte(8'(8'h90 + i), 0);
    wait_idle();
    check("rb_err", {bus.err_o, bus.rx_ready_o}, 2'b10);
    check("rb_err_cnt", bus.words_o, 0);
    compare_writes("rb_bad");
    do_start();
    send_byte(8'hAA, 0); send_byte(8'hBB, 1);
    wait_idle();
    check("rb_desel_ok", {bus.err_o, bus.rx_ready_o}, 2'b01);
    check("rb_desel_cnt", bus.words_o, 1);
    compare_writes("rb_partial");
    corrupt = 32'h0;
`endif

    // random bytes, flushes and idle gaps
    do_start();
    for (int i = 0; i < 120; i++) begin
      b = 8'($urandom);
      n = $urandom_range(0, 2);
      repeat (n) @(posedge clk);
      #0;
      send_byte(b, $urandom_range(0, 5) == 0);
    end
    do_flush();
    wait_idle();
    check("rand_cnt", bus.words_o, m_cnt);
    check("rand_err", bus.err_o, 0);
    compare_writes("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
